// File: rtl/imem_boot_loader.sv
// Boot loader: streams a length-prefixed, checksummed image into IMEM,
// releases the CPU, then holds it in reset on the first reported error.
module imem_boot_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              s_valid_i,
    input  logic [31:0]       s_data_i,
    output logic              s_ready_o,
    output logic              imem_we_o,
    output logic [31:0]       imem_addr_o,
    output logic [31:0]       imem_data_o,
    output logic              cpu_rst_o,
    input  logic              err_zero_i,
    input  logic              err_num_i,
    input  logic              addr_ovf_i,
    input  logic              misalign_i,
    output logic [2:0]        state_o,
    output logic [3:0]        err_status_o,
    output logic [1:0]        fault_o,
    output logic [ADDR_W:0]   words_loaded_o
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] CHECK = 3'd2;
    localparam logic [2:0] RUN   = 3'd3;
    localparam logic [2:0] HALT  = 3'd4;
    localparam logic [2:0] FAULT = 3'd5;

    localparam logic [31:0]     MAX_W = 32'(MAX_WORDS);
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

    logic [2:0]      state_q, state_d;
    logic [ADDR_W:0] len_q, len_d;
    logic [ADDR_W:0] cnt_q, cnt_d;
    logic [31:0]     sum_q, sum_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     data_q, data_d;
    logic            cpu_rst_q, cpu_rst_d;
    logic [3:0]      err_q, err_d;
    logic [1:0]      fault_q, fault_d;

    logic            xfer;
    logic            hdr_ok;
    logic [3:0]      err_in;
    logic [ADDR_W:0] cnt_nxt;

    assign s_ready_o = (state_q == IDLE) || (state_q == LOAD)
                    || (state_q == CHECK);
    assign xfer      = s_valid_i && s_ready_o;
    assign hdr_ok    = (s_data_i != 32'd0) && (s_data_i <= MAX_W);
    assign err_in    = {misalign_i, addr_ovf_i, err_num_i, err_zero_i};
    assign cnt_nxt   = cnt_q + ONE;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        fault_d = fault_q;
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (hdr_ok) begin
                        len_d   = s_data_i[ADDR_W:0];
                        cnt_d   = '0;
                        sum_d   = '0;
                        state_d = LOAD;
                    end else begin
                        fault_d = 2'b01;
                        state_d = FAULT;
                    end
                end
            end
            LOAD: begin
                if (xfer) begin
                    sum_d  = sum_q + s_data_i;
                    cnt_d  = cnt_nxt;
                    we_d   = 1'b1;
                    // count is always < 2^ADDR_W here, so the MSB is dropped
                    addr_d = {{(30 - ADDR_W){1'b0}},
                              cnt_q[ADDR_W-1:0], 2'b00};
                    data_d = s_data_i;
                    if (cnt_nxt == len_q) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (xfer) begin
                    if (s_data_i == sum_q) begin
                        state_d = RUN;
                    end else begin
                        fault_d = 2'b10;
                        state_d = FAULT;
                    end
                end
            end
            RUN: begin
                if (|err_in) begin
                    err_d   = err_q | err_in;
                    state_d = HALT;
                end
            end
            default: begin
            end
        endcase
        // CPU is released on the very edge that enters RUN
        cpu_rst_d = (state_d == RUN);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            sum_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            cpu_rst_q <= 1'b0;
            err_q     <= '0;
            fault_q   <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            cpu_rst_q <= cpu_rst_d;
            err_q     <= err_d;
            fault_q   <= fault_d;
        end
    end

    assign imem_we_o      = we_q;
    assign imem_addr_o    = addr_q;
    assign imem_data_o    = data_q;
    assign cpu_rst_o      = cpu_rst_q;
    assign state_o        = state_q;
    assign err_status_o   = err_q;
    assign fault_o        = fault_q;
    assign words_loaded_o = cnt_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: loads, faults, CPU error latching,
// asynchronous reset mid-load.
module tb_imem_boot_loader;

    localparam int ADDR_W    = 8;
    localparam int MAX_WORDS = 256;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            s_valid;
    logic [31:0]     s_data;
    logic            s_ready;
    logic            imem_we;
    logic [31:0]     imem_addr;
    logic [31:0]     imem_data;
    logic            cpu_rst;
    logic            err_zero, err_num, addr_ovf, misalign;
    logic [2:0]      state;
    logic [3:0]      err_status;
    logic [1:0]      fault;
    logic [ADDR_W:0] words_loaded;

    int total = 0;
    int bad   = 0;
    int we_cnt = 0;
    int we_snap;
    logic [31:0] img [4];

    imem_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .s_valid_i(s_valid), .s_data_i(s_data), .s_ready_o(s_ready),
        .imem_we_o(imem_we), .imem_addr_o(imem_addr),
        .imem_data_o(imem_data), .cpu_rst_o(cpu_rst),
        .err_zero_i(err_zero), .err_num_i(err_num),
        .addr_ovf_i(addr_ovf), .misalign_i(misalign),
        .state_o(state), .err_status_o(err_status),
        .fault_o(fault), .words_loaded_o(words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (imem_we === 1'b1) we_cnt++;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // called at a negedge; returns at the negedge after the transfer edge
    task automatic send(input logic [31:0] d);
        s_valid = 1'b1;
        s_data  = d;
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, 32'(state), 32'd0);
        check({tag, "_cpurst"}, 32'(cpu_rst), 32'd0);
        check({tag, "_ready"}, 32'(s_ready), 32'd1);
        check({tag, "_we"}, 32'(imem_we), 32'd0);
        check({tag, "_addr"}, imem_addr, 32'd0);
        check({tag, "_data"}, imem_data, 32'd0);
        check({tag, "_err"}, 32'(err_status), 32'd0);
        check({tag, "_fault"}, 32'(fault), 32'd0);
        check({tag, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    task automatic load(input string tag, input int n, input bit bad_cs);
        logic [31:0] sum;
        sum = 32'd0;
        send(32'(n));
        check({tag, "_hdr_state"}, 32'(state), 32'd1);
        for (int i = 0; i < n; i++) begin
            send(img[i]);
            sum = sum + img[i];
            check({tag, "_we"}, 32'(imem_we), 32'd1);
            check({tag, "_addr"}, imem_addr, 32'(i * 4));
            check({tag, "_data"}, imem_data, img[i]);
            check({tag, "_words"}, 32'(words_loaded), 32'(i + 1));
        end
        check({tag, "_chk_state"}, 32'(state), 32'd2);
        check({tag, "_chk_cpurst"}, 32'(cpu_rst), 32'd0);
        send(bad_cs ? sum - 32'd1 : sum);
        check({tag, "_we_off"}, 32'(imem_we), 32'd0);
        if (bad_cs) begin
            check({tag, "_st"}, 32'(state), 32'd5);
            check({tag, "_fault"}, 32'(fault), 32'd2);
            check({tag, "_cpurst"}, 32'(cpu_rst), 32'd0);
        end else begin
            check({tag, "_st"}, 32'(state), 32'd3);
            check({tag, "_fault"}, 32'(fault), 32'd0);
            check({tag, "_cpurst"}, 32'(cpu_rst), 32'd1);
        end
        check({tag, "_ready_end"}, 32'(s_ready), 32'd0);
        check({tag, "_words_end"}, 32'(words_loaded), 32'(n));
    endtask

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0;
        err_zero = 1'b0; err_num = 1'b0;
        addr_ovf = 1'b0; misalign = 1'b0;
        img[0] = 32'h2008_0005;
        img[1] = 32'h2009_0007;
        img[2] = 32'h0109_5020;
        img[3] = 32'hDEAD_BEEF;
        @(negedge clk);
        do_reset();
        check_reset_vals("rst");

        load("good", 3, 1'b0);
        check("good_err", 32'(err_status), 32'd0);

        do_reset();
        load("badcs", 3, 1'b1);

        do_reset();
        we_snap = we_cnt;
        send(32'd0);
        check("len0_state", 32'(state), 32'd5);
        check("len0_fault", 32'(fault), 32'd1);
        check("len0_ready", 32'(s_ready), 32'd0);
        @(negedge clk);
        check("len0_nowe", 32'(we_cnt), 32'(we_snap));

        do_reset();
        we_snap = we_cnt;
        send(32'(MAX_WORDS + 1));
        check("lenmax_state", 32'(state), 32'd5);
        check("lenmax_fault", 32'(fault), 32'd1);
        @(negedge clk);
        check("lenmax_nowe", 32'(we_cnt), 32'(we_snap));

        do_reset();
        load("errrun", 3, 1'b0);
        addr_ovf = 1'b1; misalign = 1'b1;
        @(negedge clk);
        addr_ovf = 1'b0; misalign = 1'b0;
        check("halt_state", 32'(state), 32'd4);
        check("halt_err", 32'(err_status), 32'hC);
        check("halt_cpurst", 32'(cpu_rst), 32'd0);
        err_zero = 1'b1;
        @(negedge clk);
        err_zero = 1'b0;
        @(negedge clk);
        check("halt_err_sticky", 32'(err_status), 32'hC);
        check("halt_stays", 32'(state), 32'd4);

        do_reset();
        send(32'd4);
        send(img[0]);
        check("tog_we0", 32'(imem_we), 32'd1);
        @(negedge clk);
        check("tog_idle_we", 32'(imem_we), 32'd0);
        send(img[1]);
        check("tog_addr1", imem_addr, 32'd4);
        @(negedge clk);
        check("tog_words", 32'(words_loaded), 32'd2);
        check("tog_state", 32'(state), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async");
        @(negedge clk);
        rst_n = 1'b1;
        img[0] = 32'h1234_5678;
        img[1] = 32'h8765_4321;
        load("reload", 2, 1'b0);

        do_reset();
        err_zero = 1'b1; err_num = 1'b1;
        addr_ovf = 1'b1; misalign = 1'b1;
        img[0] = 32'h2008_0005;
        img[1] = 32'h2009_0007;
        img[2] = 32'h0109_5020;
        load("errhi", 3, 1'b0);
        check("errhi_err_pre", 32'(err_status), 32'd0);
        @(negedge clk);
        check("errhi_halt", 32'(state), 32'd4);
        check("errhi_err", 32'(err_status), 32'hF);
        err_zero = 1'b0; err_num = 1'b0;
        addr_ovf = 1'b0; misalign = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
